// File: rtl/fast_core_data_ram_pipelined.sv
// Parametrised FP51 data RAM: optional output register, write-first forwarding,
// full-width range check and a post-reset clear sweep.
module fast_core_data_ram_pipelined #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 8192,
    parameter int ADDR_WIDTH     = 16,
    parameter int OUT_REG        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_req,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  addr_err,
    output logic                  busy,
    output logic                  dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_v1;
    logic                  r_rerr1;
    logic                  r_werr;
    logic [DATA_WIDTH-1:0] r_d1;

    logic                  w_rd_oor;
    logic                  w_wr_oor;
    logic                  w_active;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_fwd;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_wd;
    logic                  w_rerr_out;

    // Range check at full address width plus one bit, so no alias can slip through.
    assign w_rd_oor = ({1'b0, read_addr} >= DEPTH_L);
    assign w_wr_oor = ({1'b0, write_addr} >= DEPTH_L);
    assign w_active = !reset && (r_state == S_READY);
    assign w_rd_acc = w_active && read_req;
    assign w_wr_acc = w_active && we && !w_wr_oor;
    assign w_fwd    = w_wr_acc && (write_addr == read_addr);
    assign w_rd_idx = read_addr[IDX_W-1:0];
    assign w_wr_idx = write_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state <= S_READY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_READY;
            endcase
        end
    end

    // One shared write port: the sweep owns it while clearing.
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = w_wr_idx;
        w_mem_wd  = data_in;
        if (!reset && (r_state == S_CLEAR)) begin
            w_mem_we  = 1'b1;
            w_mem_idx = r_cnt;
            w_mem_wd  = '0;
        end else if (w_wr_acc) begin
            w_mem_we  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1    <= 1'b0;
            r_rerr1 <= 1'b0;
            r_werr  <= 1'b0;
            r_d1    <= '0;
        end else begin
            r_v1    <= w_rd_acc;
            r_rerr1 <= w_rd_acc && w_rd_oor;
            r_werr  <= w_active && we && w_wr_oor;
            if (w_rd_acc) begin
                r_d1 <= w_rd_oor ? '0 : (w_fwd ? data_in : r_mem[w_rd_idx]);
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_v2;
            logic                  r_rerr2;
            logic [DATA_WIDTH-1:0] r_d2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v2    <= 1'b0;
                    r_rerr2 <= 1'b0;
                    r_d2    <= '0;
                end else begin
                    r_v2    <= r_v1;
                    r_rerr2 <= r_rerr1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign data_out   = r_d2;
            assign data_valid = r_v2;
            assign w_rerr_out = r_rerr2;
        end else begin : g_no_out_reg
            assign data_out   = r_d1;
            assign data_valid = r_v1;
            assign w_rerr_out = r_rerr1;
        end
    endgenerate

    // Write and read error pulses that land in the same cycle merge into one strobe.
    assign addr_err  = r_werr | w_rerr_out;
    assign busy      = (r_state == S_CLEAR);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fast_core_data_ram_pipelined.sv
// Directed bench for fast_core_data_ram_pipelined: two DEPTH=16 instances (1- and
// 2-cycle latency) plus a 32-bit DEPTH=1000 instance share one stimulus stream.
module tb_fast_core_data_ram_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_req;
    logic [15:0] read_addr;
    logic        we;
    logic [15:0] write_addr;
    logic [31:0] data_in;

    logic [7:0]  d0_out;
    logic        d0_v, d0_err, d0_busy, d0_st;
    logic [7:0]  d1_out;
    logic        d1_v, d1_err, d1_busy, d1_st;
    logic [31:0] d2_out;
    logic        d2_v, d2_err, d2_busy, d2_st;

    int errors = 0;
    int checks = 0;

    logic [15:0] b_addr [16];
    logic [7:0]  b_exp  [16];
    logic        b_err  [16];

    int n0, n1, n2, stray;

    always #5 clk = ~clk;

    fast_core_data_ram_pipelined #(
        .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(16), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .we(we), .write_addr(write_addr), .data_in(data_in[7:0]),
        .data_out(d0_out), .data_valid(d0_v), .addr_err(d0_err),
        .busy(d0_busy), .dbg_state(d0_st)
    );

    fast_core_data_ram_pipelined #(
        .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(16), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .we(we), .write_addr(write_addr), .data_in(data_in[7:0]),
        .data_out(d1_out), .data_valid(d1_v), .addr_err(d1_err),
        .busy(d1_busy), .dbg_state(d1_st)
    );

    fast_core_data_ram_pipelined #(
        .DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(16), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut2 (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .we(we), .write_addr(write_addr), .data_in(data_in),
        .data_out(d2_out), .data_valid(d2_v), .addr_err(d2_err),
        .busy(d2_busy), .dbg_state(d2_st)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        we         = 1'b1;
        write_addr = a;
        data_in    = d;
        tick();
        we         = 1'b0;
    endtask

    // Back-to-back reads of b_addr[0..n-1]; dut0 answers one cycle later, dut1 two.
    task automatic rd_burst(input int n);
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                read_req  = 1'b1;
                read_addr = b_addr[c];
            end else begin
                read_req  = 1'b0;
                read_addr = 16'h0;
            end
            tick();
            chk("d0_valid", 32'(d0_v), 32'(c < n));
            if (c < n) begin
                chk("d0_data", 32'(d0_out), 32'(b_exp[c]));
                chk("d0_err", 32'(d0_err), 32'(b_err[c]));
            end
            chk("d1_valid", 32'(d1_v), 32'(c >= 1 && c <= n));
            if (c >= 1 && c <= n) begin
                chk("d1_data", 32'(d1_out), 32'(b_exp[c-1]));
                chk("d1_err", 32'(d1_err), 32'(b_err[c-1]));
            end
        end
        read_req = 1'b0;
        chk("d0_hold", 32'(d0_out), 32'(b_exp[n-1]));
        chk("d1_hold", 32'(d1_out), 32'(b_exp[n-1]));
    endtask

    // Counts busy cycles of each instance from now until all are ready; with
    // poke set, fires accesses during the first three busy cycles.
    task automatic wait_ready(input bit poke);
        n0 = 0; n1 = 0; n2 = 0; stray = 0;
        for (int i = 0; i < 1200; i++) begin
            stray += int'(d0_v | d0_err | d1_v | d1_err | d2_v | d2_err);
            if (!d0_busy && !d1_busy && !d2_busy) break;
            n0 += int'(d0_busy);
            n1 += int'(d1_busy);
            n2 += int'(d2_busy);
            if (poke && i < 3) begin
                read_req = 1'b1; read_addr = 16'h2;
                we = 1'b1; write_addr = 16'h10; data_in = 32'h77;
            end else begin
                read_req = 1'b0; we = 1'b0;
            end
            tick();
        end
        read_req = 1'b0;
        we       = 1'b0;
    endtask

    initial begin
        reset = 1'b1; read_req = 1'b0; read_addr = '0;
        we = 1'b0; write_addr = '0; data_in = '0;
        tick();
        tick();
        chk("rst_d0_valid", 32'(d0_v), 32'd0);
        chk("rst_d0_err", 32'(d0_err), 32'd0);
        chk("rst_d0_busy", 32'(d0_busy), 32'd1);
        chk("rst_d0_out", 32'(d0_out), 32'd0);
        chk("rst_d1_out", 32'(d1_out), 32'd0);
        chk("rst_d2_busy", 32'(d2_busy), 32'd1);
        reset = 1'b0;
        wait_ready(1'b0);
        chk("sweep0_d0_len", 32'(n0), 32'd16);
        chk("sweep0_d2_len", 32'(n2), 32'd1000);

        for (int i = 0; i < 16; i++) wr(16'(i), 32'hC0 + 32'(i));
        read_req = 1'b1; read_addr = 16'h5;
        tick();
        chk("preload_d0_valid", 32'(d0_v), 32'd1);
        chk("preload_d0_data", 32'(d0_out), 32'hC5);
        read_req = 1'b0; reset = 1'b1;
        tick();
        chk("flush_d1_valid", 32'(d1_v), 32'd0);
        chk("flush_d1_out", 32'(d1_out), 32'd0);
        chk("flush_d0_out", 32'(d0_out), 32'd0);
        tick();
        reset = 1'b0;
        wait_ready(1'b0);
        chk("sweep1_d0_len", 32'(n0), 32'd16);
        chk("sweep1_d1_len", 32'(n1), 32'd16);
        chk("sweep1_d2_len", 32'(n2), 32'd1000);
        for (int i = 0; i < 16; i++) begin
            b_addr[i] = 16'(i); b_exp[i] = 8'h00; b_err[i] = 1'b0;
        end
        rd_burst(16);

        wr(16'd3, 32'hA5);
        wr(16'd4, 32'h5A);
        wr(16'd15, 32'hFF);
        b_addr[0] = 16'd3;  b_exp[0] = 8'hA5; b_err[0] = 1'b0;
        b_addr[1] = 16'd4;  b_exp[1] = 8'h5A; b_err[1] = 1'b0;
        b_addr[2] = 16'd15; b_exp[2] = 8'hFF; b_err[2] = 1'b0;
        rd_burst(3);

        wr(16'd7, 32'h11);
        we = 1'b1; write_addr = 16'd7; data_in = 32'h22;
        read_req = 1'b1; read_addr = 16'd7;
        tick();
        we = 1'b0; read_req = 1'b0;
        chk("fwd_d0_valid", 32'(d0_v), 32'd1);
        chk("fwd_d0_data", 32'(d0_out), 32'h22);
        tick();
        chk("fwd_d1_valid", 32'(d1_v), 32'd1);
        chk("fwd_d1_data", 32'(d1_out), 32'h22);
        we = 1'b1; write_addr = 16'd8; data_in = 32'h33;
        read_req = 1'b1; read_addr = 16'd3;
        tick();
        we = 1'b0; read_req = 1'b0;
        chk("rdw_diff_d0_data", 32'(d0_out), 32'hA5);
        tick();
        chk("rdw_diff_d1_data", 32'(d1_out), 32'hA5);
        b_addr[0] = 16'd7; b_exp[0] = 8'h22; b_err[0] = 1'b0;
        b_addr[1] = 16'd8; b_exp[1] = 8'h33; b_err[1] = 1'b0;
        rd_burst(2);

        wr(16'd0, 32'h44);
        wr(16'd16, 32'h99);
        chk("oor_wr_d0_err", 32'(d0_err), 32'd1);
        chk("oor_wr_d1_err", 32'(d1_err), 32'd1);
        tick();
        chk("oor_wr_d0_err_end", 32'(d0_err), 32'd0);
        b_addr[0] = 16'd0;  b_exp[0] = 8'h44; b_err[0] = 1'b0;
        b_addr[1] = 16'h10; b_exp[1] = 8'h00; b_err[1] = 1'b1;
        b_addr[2] = 16'd4;  b_exp[2] = 8'h5A; b_err[2] = 1'b0;
        rd_burst(3);

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (9) tick();
        chk("mid_d0_busy", 32'(d0_busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_d0_busy", 32'(d0_busy), 32'd1);
        reset = 1'b0;
        wait_ready(1'b1);
        chk("restart_d0_len", 32'(n0), 32'd16);
        chk("restart_d1_len", 32'(n1), 32'd16);
        chk("restart_d2_len", 32'(n2), 32'd1000);
        chk("busy_no_strobes", 32'(stray), 32'd0);
        b_addr[0] = 16'd15; b_exp[0] = 8'h00; b_err[0] = 1'b0;
        b_addr[1] = 16'd0;  b_exp[1] = 8'h00; b_err[1] = 1'b0;
        rd_burst(2);

        wr(16'd999, 32'hDEADBEEF);
        read_req = 1'b1; read_addr = 16'd999;
        tick();
        read_req = 1'b0;
        chk("w32_lat_valid", 32'(d2_v), 32'd0);
        tick();
        chk("w32_valid", 32'(d2_v), 32'd1);
        chk("w32_data", d2_out, 32'hDEADBEEF);
        chk("w32_err", 32'(d2_err), 32'd0);
        wr(16'd1000, 32'h1);
        chk("w32_oor_wr_err", 32'(d2_err), 32'd1);
        read_req = 1'b1; read_addr = 16'd1000;
        tick();
        read_req = 1'b0;
        tick();
        chk("w32_oor_rd_valid", 32'(d2_v), 32'd1);
        chk("w32_oor_rd_data", d2_out, 32'h0);
        chk("w32_oor_rd_err", 32'(d2_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
